sc_point_datapath: RTL and testbench
====================================

Name: sc_point_datapath

Overview:
- Datapath and timer responder driven by the point-game control state machine.
- Holds the falling point's position as a one-hot column and a binary row.
- Executes the FSM's active-low clear, load1 (drop one row), shift-selection and upcount/clear-counter commands.
- Returns the active-low T0 timeout and bottom-side comparator flags that the FSM branches on.

Parameters:
- COLS, 8, width of the one-hot column register (≥2, even).
- ROWS, 8, number of rows; row index width is clog2(ROWS).
- T0_LIMIT, 4, number of upcount strobes before T0 asserts (≥1).

Ports:
- SC_POINTDATAPATH_CLOCK_50  in  1  system clock; all state updates on rising edge.
- SC_POINTDATAPATH_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_POINTDATAPATH_clear_InLow  in  1  0 = re-center the point (column COLS/2, row 0).
- SC_POINTDATAPATH_load1_InLow  in  1  0 = move the point down one row.
- SC_POINTDATAPATH_shiftselection_In  in  2  01 = left (toward MSB), 10 = right (toward LSB), 11/00 = hold.
- SC_POINTDATAPATH_upcount_InLow  in  1  0 = increment the timer.
- SC_POINTDATAPATH_clearcounter_InLow  in  1  0 = zero the timer.
- SC_POINTDATAPATH_T0_OutLow  out  1  0 when timer == T0_LIMIT.
- SC_POINTDATAPATH_bottomsidecomparator_OutLow  out  1  0 when row == ROWS-1.
- SC_POINTDATAPATH_column_Out  out  COLS  one-hot column register.
- SC_POINTDATAPATH_row_Out  out  clog2(ROWS)  binary row register.
- SC_POINTDATAPATH_rowdecode_Out  out  ROWS  one-hot decode of row (bit[row] = 1).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of SC_POINTDATAPATH_CLOCK_50. Reset dominates every command.
- Reset values:
  - column = 1<<(COLS/2); row = 0; timer = 0.
  - T0_OutLow = 1 (when T0_LIMIT ≥ 1); bottomsidecomparator_OutLow = 1.
  - rowdecode = 1; column_Out and row_Out equal their registers.
- Latency: a command sampled at edge n is visible on the outputs after edge n. The flags are combinational decodes of the registers, so there is no extra cycle.
- Position register priority within one cycle: clear > load1 > shift.
  - clear low: column = 1<<(COLS/2), row = 0. load1 and shift are ignored.
  - load1 low (clear high): row = row+1 if row < ROWS-1, else hold (saturate, no wrap). Shift is ignored that cycle.
  - shift 01: column = column<<1 unless column[COLS-1] = 1, in which case hold (no wrap).
  - shift 10: column = column>>1 unless column[0] = 1, in which case hold.
  - shift 11/00: hold.
- Column stays strictly one-hot: no command ever yields zero or multiple bits.
- Timer (sub-module), width clog2(T0_LIMIT+1):
  - clearcounter low: timer = 0; it wins over a simultaneous upcount.
  - upcount low: timer = timer+1 if timer < T0_LIMIT, else hold (saturate).
  - T0_OutLow = ~(timer == T0_LIMIT); it stays low until clearcounter.
- Timer and position paths are independent; simultaneous commands on both act in the same cycle.
- bottomsidecomparator_OutLow = ~(row == ROWS-1).
- Reset mid-operation: all registers return to reset values on that edge, regardless of the pending commands.
- No internal FSM beyond the two registers and the saturating counter.

Decomposition:
- Package sc_point_pkg:
  - shift-selection encodings SHIFT_HOLD = 2'b11, SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10, SHIFT_NOP = 2'b00.
  - Active-low assert/deassert constants.
  - Function computing the center one-hot column.
- Sub-module sc_point_timer: the saturating upcount/clear counter and the T0 compare, parameterised by T0_LIMIT.
- The position register and decodes stay in the top module.

Test Plan:
- Reset then idle (all inputs high, shift 11): column = 8'b0001_0000, row = 0, rowdecode = 8'b0000_0001, T0 = 1, bottom = 1, held for 10 cycles.
- Four shift 01 cycles from reset: column goes 0x20, 0x40, 0x80, then stays 0x80. Ten shift 10 cycles: column reaches 0x01 and stays; never zero.
- Seven load1 pulses: row 1..7. bottomsidecomparator goes low right after the 7th. An 8th load1 keeps row = 7. A clear then gives row 0, column 0x10, bottom high.
- Four upcount strobes (T0_LIMIT = 4): T0 low after the 4th edge; a 5th upcount keeps it low. clearcounter gives timer 0 and T0 high the next cycle.
- Same-cycle conflicts:
  - clear + load1 + shift 01 at row 3, column 0x04: gives row 0, column 0x10.
  - upcount + clearcounter at timer 3: gives timer 0.
  - load1 + shift 10: row+1, column unchanged.
- Reset asserted mid-sequence (row 5, column 0x02, timer 3) with upcount and load1 also low: all registers return to reset values; T0 = 1, bottom = 1.

Source files
------------

// File: rtl/sc_point_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_point_pkg
// Purpose  : Shared encodings and helpers for the falling-point datapath.
// Revision : 1.0 - initial release
// ============================================================================
package sc_point_pkg;

  localparam logic [1:0] SHIFT_NOP   = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam logic ACT_LOW_ASSERT   = 1'b0;
  localparam logic ACT_LOW_DEASSERT = 1'b1;

  localparam int MAX_COLS = 64;

  // One-hot column with the point re-centred; callers truncate to their width.
  function automatic logic [MAX_COLS-1:0] centerColumn(input int cols);
    return MAX_COLS'(1) << (cols / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_point_timer.sv
`default_nettype none
// ============================================================================
// Module   : sc_point_timer
// Purpose  : Saturating up-counter with clear; flags T0 when it hits T0_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module sc_point_timer
  import sc_point_pkg::*;
#(
  parameter int T0_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_upcountLow,
  input  logic i_clearCounterLow,
  output logic o_t0Low
);

  localparam int TW = $clog2(T0_LIMIT + 1);
  localparam logic [TW-1:0] c_LIMIT = TW'(T0_LIMIT);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clearCounterLow == ACT_LOW_ASSERT) begin
      r_count <= '0;
    end else if (i_upcountLow == ACT_LOW_ASSERT && r_count < c_LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_t0Low = ~(r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sc_point_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sc_point_datapath
// Purpose  : Falling-point position registers, decodes and T0 timer responder.
// Revision : 1.0 - initial release
// ============================================================================
module sc_point_datapath
  import sc_point_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int T0_LIMIT = 4
) (
  input  logic                    SC_POINTDATAPATH_CLOCK_50,
  input  logic                    SC_POINTDATAPATH_RESET_InHigh,
  input  logic                    SC_POINTDATAPATH_clear_InLow,
  input  logic                    SC_POINTDATAPATH_load1_InLow,
  input  logic [1:0]              SC_POINTDATAPATH_shiftselection_In,
  input  logic                    SC_POINTDATAPATH_upcount_InLow,
  input  logic                    SC_POINTDATAPATH_clearcounter_InLow,
  output logic                    SC_POINTDATAPATH_T0_OutLow,
  output logic                    SC_POINTDATAPATH_bottomsidecomparator_OutLow,
  output logic [COLS-1:0]         SC_POINTDATAPATH_column_Out,
  output logic [$clog2(ROWS)-1:0] SC_POINTDATAPATH_row_Out,
  output logic [ROWS-1:0]         SC_POINTDATAPATH_rowdecode_Out
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COLS-1:0]  c_CENTER_COLUMN = COLS'(centerColumn(COLS));
  localparam logic [ROW_W-1:0] c_LAST_ROW      = ROW_W'(ROWS - 1);

  logic [COLS-1:0]  r_column;
  logic [ROW_W-1:0] r_row;

  // clear beats load1, and load1 beats shift; edges saturate so the column stays one-hot.
  always_ff @(posedge SC_POINTDATAPATH_CLOCK_50) begin
    if (SC_POINTDATAPATH_RESET_InHigh) begin
      r_column <= c_CENTER_COLUMN;
      r_row    <= '0;
    end else if (SC_POINTDATAPATH_clear_InLow == ACT_LOW_ASSERT) begin
      r_column <= c_CENTER_COLUMN;
      r_row    <= '0;
    end else if (SC_POINTDATAPATH_load1_InLow == ACT_LOW_ASSERT) begin
      if (r_row < c_LAST_ROW) begin
        r_row <= r_row + 1'b1;
      end
    end else begin
      case (SC_POINTDATAPATH_shiftselection_In)
        SHIFT_LEFT: begin
          if (!r_column[COLS-1]) r_column <= r_column << 1;
        end
        SHIFT_RIGHT: begin
          if (!r_column[0]) r_column <= r_column >> 1;
        end
        default: begin
          r_column <= r_column;
        end
      endcase
    end
  end

  sc_point_timer #(
    .T0_LIMIT (T0_LIMIT)
  ) u_timer (
    .clk               (SC_POINTDATAPATH_CLOCK_50),
    .rst               (SC_POINTDATAPATH_RESET_InHigh),
    .i_upcountLow      (SC_POINTDATAPATH_upcount_InLow),
    .i_clearCounterLow (SC_POINTDATAPATH_clearcounter_InLow),
    .o_t0Low           (SC_POINTDATAPATH_T0_OutLow)
  );

  assign SC_POINTDATAPATH_column_Out                  = r_column;
  assign SC_POINTDATAPATH_row_Out                     = r_row;
  assign SC_POINTDATAPATH_rowdecode_Out               = ROWS'(1) << r_row;
  assign SC_POINTDATAPATH_bottomsidecomparator_OutLow = ~(r_row == c_LAST_ROW);

endmodule
`default_nettype wire

// File: tb/tb_sc_point_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_point_datapath
// Purpose  : Directed plus random checks of sc_point_datapath against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_point_datapath;

  localparam int COLS     = 8;
  localparam int ROWS     = 8;
  localparam int T0_LIMIT = 4;
  localparam int ROW_W    = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             rst, clr, ld, up, cc;
  logic [1:0]       sh;
  logic             t0Low, bottomLow;
  logic [COLS-1:0]  column;
  logic [ROW_W-1:0] row;
  logic [ROWS-1:0]  rowDecode;

  int nVectors    = 0;
  int nMiscompares = 0;

  // Reference model: point as plain column/row indices, timer as an integer.
  int mCol, mRow, mTmr;

  sc_point_datapath #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .T0_LIMIT (T0_LIMIT)
  ) dut (
    .SC_POINTDATAPATH_CLOCK_50                    (clk),
    .SC_POINTDATAPATH_RESET_InHigh                (rst),
    .SC_POINTDATAPATH_clear_InLow                 (clr),
    .SC_POINTDATAPATH_load1_InLow                 (ld),
    .SC_POINTDATAPATH_shiftselection_In           (sh),
    .SC_POINTDATAPATH_upcount_InLow               (up),
    .SC_POINTDATAPATH_clearcounter_InLow          (cc),
    .SC_POINTDATAPATH_T0_OutLow                   (t0Low),
    .SC_POINTDATAPATH_bottomsidecomparator_OutLow (bottomLow),
    .SC_POINTDATAPATH_column_Out                  (column),
    .SC_POINTDATAPATH_row_Out                     (row),
    .SC_POINTDATAPATH_rowdecode_Out               (rowDecode)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      nMiscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    if (rst) begin
      mCol = COLS / 2; mRow = 0; mTmr = 0;
    end else begin
      if (!clr) begin
        mCol = COLS / 2; mRow = 0;
      end else if (!ld) begin
        if (mRow < ROWS - 1) mRow++;
      end else if (sh == 2'b01) begin
        if (mCol < COLS - 1) mCol++;
      end else if (sh == 2'b10) begin
        if (mCol > 0) mCol--;
      end
      if (!cc) mTmr = 0;
      else if (!up && mTmr < T0_LIMIT) mTmr++;
    end
  endtask

  task automatic checkAll(input string tag);
    cmp({tag, "_column"},    32'(column),    32'(1) << mCol);
    cmp({tag, "_row"},       32'(row),       32'(mRow));
    cmp({tag, "_rowdecode"}, 32'(rowDecode), 32'(1) << mRow);
    cmp({tag, "_t0"},        32'(t0Low),     32'(mTmr != T0_LIMIT));
    cmp({tag, "_bottom"},    32'(bottomLow), 32'(mRow != ROWS - 1));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelStep();
    nVectors++;
    #1;
    checkAll(tag);
  endtask

  task automatic idle();
    rst = 1'b0; clr = 1'b1; ld = 1'b1; up = 1'b1; cc = 1'b1; sh = 2'b11;
  endtask

  initial begin
    idle();
    mCol = 0; mRow = 0; mTmr = 0;
    rst = 1'b1;
    cycle("reset");
    cycle("reset");
    cmp("reset_col_const", 32'(column), 32'h10);
    cmp("reset_dec_const", 32'(rowDecode), 32'h01);
    idle();
    for (int i = 0; i < 10; i++) cycle("idle");
    cmp("idle_col_const", 32'(column), 32'h10);

    // Left shifts saturate at the MSB.
    sh = 2'b01;
    for (int i = 0; i < 4; i++) cycle("shl");
    cmp("shl_sat_const", 32'(column), 32'h80);
    sh = 2'b10;
    for (int i = 0; i < 10; i++) cycle("shr");
    cmp("shr_sat_const", 32'(column), 32'h01);
    idle();

    // Drop to the bottom row and past it.
    clr = 1'b0; cycle("clr"); clr = 1'b1;
    ld = 1'b0;
    for (int i = 0; i < 7; i++) cycle("load");
    cmp("bottom_const", 32'(bottomLow), 32'h0);
    cycle("load_sat");
    cmp("row_sat_const", 32'(row), 32'h7);
    ld = 1'b1; clr = 1'b0; cycle("clr_after_bottom"); clr = 1'b1;
    cmp("clr_col_const", 32'(column), 32'h10);

    // Timer saturation and clear.
    up = 1'b0;
    for (int i = 0; i < 5; i++) cycle("upcount");
    cmp("t0_const", 32'(t0Low), 32'h0);
    up = 1'b1; cc = 1'b0; cycle("clrcnt"); cc = 1'b1;
    cmp("t0_clr_const", 32'(t0Low), 32'h1);

    // clear + load1 + shift-left from row 3, column 0x04.
    ld = 1'b0; for (int i = 0; i < 3; i++) cycle("setup_row"); ld = 1'b1;
    sh = 2'b10; for (int i = 0; i < 2; i++) cycle("setup_col");
    cmp("setup_col_const", 32'(column), 32'h04);
    clr = 1'b0; ld = 1'b0; sh = 2'b01; cycle("conflict_pos"); idle();
    // upcount + clearcounter at timer 3: needs 4 more strobes to reach T0.
    up = 1'b0; for (int i = 0; i < 3; i++) cycle("up3");
    cc = 1'b0; cycle("conflict_tmr"); cc = 1'b1;
    for (int i = 0; i < 3; i++) cycle("up_after_clr");
    cmp("t0_not_yet_const", 32'(t0Low), 32'h1);
    cycle("up_fourth");
    up = 1'b1;
    // load1 + shift-right: row advances, column holds.
    ld = 1'b0; sh = 2'b10; cycle("load_vs_shift"); idle();

    // Mid-operation reset with load1 and upcount also pending.
    clr = 1'b0; cycle("pre_rst_clr"); clr = 1'b1; cc = 1'b0; cycle("pre_rst_cc"); cc = 1'b1;
    ld = 1'b0; for (int i = 0; i < 5; i++) cycle("pre_rst_row"); ld = 1'b1;
    sh = 2'b10; for (int i = 0; i < 3; i++) cycle("pre_rst_col"); sh = 2'b11;
    up = 1'b0; for (int i = 0; i < 3; i++) cycle("pre_rst_tmr");
    ld = 1'b0; rst = 1'b1; cycle("mid_reset");
    cmp("mid_rst_col_const", 32'(column), 32'h10);
    idle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 3) != 0);
      sh  = 2'($urandom_range(0, 3));
      up  = ($urandom_range(0, 1) != 0);
      cc  = ($urandom_range(0, 7) != 0);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
`default_nettype wire
